if_prefetch: RTL and testbench

Parametrised instruction prefetch unit that replaces the bare PC register plus direct ROM path in the fetch stage. It issues sequential fetches to the instruction ROM over a request/valid handshake with arbitrary response latency. Returned instructions and their PCs are buffered in a DEPTH-entry FIFO and presented to the IF/ID register through a valid/ready handshake. A redirect input handles branches and jumps: it flushes the buffer, discards any in-flight response, and restarts fetch at a new PC.

---
 rtl/if_prefetch.sv | 134 +++++++++++++
 tb/tb_if_prefetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch unit with a redirect-flushable FIFO
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rom_req_o/addr_o    one-cycle fetch strobe and fetch address (fetch_pc)
//   rom_valid_i/data_i  one-cycle ROM response and its instruction
//   inst_valid_o/o/pc_o FIFO head toward IF/ID
//   inst_ready_i        consumer accepts the head
//   redirect_i/pc_i     flush FIFO, drop in-flight response, restart at new PC
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_valid_i,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_W / 8);

  // S_WAIT keeps the pending response, S_DROP swallows it (a redirect hit
  // while it was in flight).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic head_valid;
  logic issue;
  logic enq;
  logic deq;

  // A redirect suppresses every other event in its cycle, so it masks
  // issue, enqueue and dequeue alike.
  always_comb begin
    head_valid = (count != '0);
    issue      = rst & (state == S_IDLE) & ~redirect_i & (count < FULL_CNT);
    enq        = rst & (state == S_WAIT) & rom_valid_i & ~redirect_i;
    deq        = rst & head_valid & inst_ready_i & ~redirect_i;
  end

  assign rom_req_o    = issue;
  assign rom_addr_o   = rst ? fetch_pc : RESET_PC;
  assign inst_valid_o = rst & head_valid;
  assign inst_o       = rst ? inst_mem[rd_ptr] : '0;
  assign inst_pc_o    = rst ? pc_mem[rd_ptr] : '0;

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc_i;
      // A response landing in the redirect cycle is simply discarded; one
      // still in flight has to be swallowed later in S_DROP.
      unique case (state)
        S_IDLE:  state <= S_IDLE;
        S_WAIT:  state <= rom_valid_i ? S_IDLE : S_DROP;
        S_DROP:  state <= rom_valid_i ? S_IDLE : S_DROP;
        default: state <= S_IDLE;
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_valid_i) begin
            fetch_pc <= fetch_pc + PC_STEP;
            state    <= S_IDLE;
          end
        end
        S_DROP: begin
          if (rom_valid_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized bench for if_prefetch against a queue-level reference model
module tb_if_prefetch;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_valid_i;
  logic [31:0] rom_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  if_prefetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_valid_i  (rom_valid_i),
    .rom_data_i   (rom_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected instruction stream as plain queues.
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pcq[$];
  logic [31:0] m_inq[$];
  bit          m_out;
  bit          m_drop;

  // ROM responder.
  bit          pend;
  int          rem;
  logic [31:0] pend_addr;

  // Stimulus knobs.
  int          lat_min, lat_max, ready_pct, redir_pct;
  bit          force_redir;
  logic [31:0] force_pc;
  bit          redir_on_valid;
  logic [31:0] rov_pc;
  bit          rov_fired;
  bit          rst_drive;
  bit          last_req;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: observed %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic cycle();
    logic exp_req;
    logic exp_valid;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    rom_valid_i = 1'b0;
    rom_data_i  = $urandom;
    if (pend) begin
      rem--;
      if (rem <= 0) begin
        rom_valid_i = 1'b1;
        rom_data_i  = rom_fn(pend_addr);
        pend        = 1'b0;
      end
    end
    inst_ready_i  = ($urandom_range(99) < ready_pct);
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom;
    if (force_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = force_pc;
    end else if (redir_on_valid && rom_valid_i && m_pcq.size() != 0 && inst_ready_i && rst_drive) begin
      redirect_i    = 1'b1;
      redirect_pc_i = rov_pc;
      rov_fired     = 1'b1;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect_i    = 1'b1;
      redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                               : ($urandom & ~32'h3);
    end
    rst = rst_drive;
    #1;
    if (!rst) begin
      check_eq("rst_req",   32'(rom_req_o),    32'h0);
      check_eq("rst_valid", 32'(inst_valid_o), 32'h0);
      check_eq("rst_addr",  rom_addr_o,        32'h0);
      check_eq("rst_inst",  inst_o,            32'h0);
      check_eq("rst_pc",    inst_pc_o,         32'h0);
      m_pcq.delete();
      m_inq.delete();
      m_fetch_pc = 32'h0;
      m_out      = 1'b0;
      m_drop     = 1'b0;
      last_req   = 1'b0;
    end else begin
      exp_req   = !m_out && !redirect_i && (m_pcq.size() < DEPTH);
      exp_valid = (m_pcq.size() != 0);
      check_eq("req",   32'(rom_req_o),    32'(exp_req));
      check_eq("addr",  rom_addr_o,        m_fetch_pc);
      check_eq("valid", 32'(inst_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check_eq("inst",    inst_o,    m_inq[0]);
        check_eq("inst_pc", inst_pc_o, m_pcq[0]);
      end
      last_req = rom_req_o;
      if (rom_req_o) begin
        pend      = 1'b1;
        rem       = $urandom_range(lat_max, lat_min);
        pend_addr = rom_addr_o;
      end
      if (redirect_i) begin
        m_pcq.delete();
        m_inq.delete();
        m_fetch_pc = redirect_pc_i;
        if (m_out) begin
          if (rom_valid_i) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
          end else begin
            m_drop = 1'b1;
          end
        end
      end else begin
        if (exp_valid && inst_ready_i) begin
          void'(m_pcq.pop_front());
          void'(m_inq.pop_front());
        end
        if (m_out && rom_valid_i) begin
          if (!m_drop) begin
            m_pcq.push_back(m_fetch_pc);
            m_inq.push_back(rom_fn(m_fetch_pc));
            m_fetch_pc = m_fetch_pc + 32'd4;
          end
          m_out  = 1'b0;
          m_drop = 1'b0;
        end
        if (exp_req) m_out = 1'b1;
      end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b0; rom_valid_i = 1'b0; rom_data_i = '0; inst_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    m_fetch_pc = '0; m_out = 0; m_drop = 0; pend = 0; rem = 0; pend_addr = '0;
    lat_min = 1; lat_max = 1; ready_pct = 0; redir_pct = 0;
    force_redir = 0; force_pc = '0; redir_on_valid = 0; rov_pc = '0; rov_fired = 0;
    rst_drive = 1'b0; last_req = 0;

    repeat (3) cycle();

    // Release reset with a 1-cycle ROM; fill the FIFO with no consumer, then drain.
    rst_drive = 1'b1;
    repeat (12) cycle();
    ready_pct = 100;
    repeat (10) cycle();

    // Redirect to 0x100 while a 3-cycle request is outstanding.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      found = last_req;
    end
    check_eq("wait_req_for_redirect", 32'(found), 32'h1);
    force_redir = 1; force_pc = 32'h100;
    cycle();
    force_redir = 0;
    repeat (15) cycle();

    // Redirect coinciding with a WAIT-state response and a dequeue.
    lat_min = 1; lat_max = 1; ready_pct = 0;
    repeat (8) cycle();
    ready_pct = 100; redir_on_valid = 1; rov_pc = 32'h200; rov_fired = 0;
    for (int i = 0; i < 50 && !rov_fired; i++) cycle();
    check_eq("redirect_on_valid_hit", 32'(rov_fired), 32'h1);
    redir_on_valid = 0;
    repeat (8) cycle();

    // Fetch PC wrap past 0xFFFFFFFC.
    force_redir = 1; force_pc = 32'hFFFF_FFF8;
    cycle();
    force_redir = 0;
    repeat (10) cycle();

    // One-cycle reset with two entries buffered and a request in flight; the
    // late response lands in the first cycle after release.
    lat_min = 3; lat_max = 3; ready_pct = 0;
    force_redir = 1; force_pc = 32'h40;
    cycle();
    force_redir = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      found = last_req && (m_pcq.size() == 2);
    end
    check_eq("wait_two_buffered", 32'(found), 32'h1);
    cycle();
    rst_drive = 1'b0;
    cycle();
    rst_drive = 1'b1;
    repeat (12) cycle();

    // Randomized traffic.
    redir_pct = 4;
    for (int blk = 0; blk < 60; blk++) begin
      lat_min = $urandom_range(4, 1);
      lat_max = lat_min + $urandom_range(2);
      case ($urandom_range(3))
        0: ready_pct = 0;
        1: ready_pct = 30;
        2: ready_pct = 70;
        default: ready_pct = 100;
      endcase
      repeat (50) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
